// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: grants up to NUM_CDB finished FU results per cycle
// in rotating-priority order and broadcasts them on registered CDB lanes.
module cdb_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_CDB   = 2,
  parameter int ROB_IDX_W = 5,
  parameter int RD_W      = 5,
  parameter int DATA_LEN  = 32,
  localparam int SRC_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][ROB_IDX_W-1:0]   req_robid,
  input  logic [NUM_REQ-1:0][RD_W-1:0]        req_rd,
  input  logic [NUM_REQ-1:0][DATA_LEN-1:0]    req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_CDB-1:0]                  cdb_valid,
  output logic [NUM_CDB-1:0][ROB_IDX_W-1:0]   cdb_robid,
  output logic [NUM_CDB-1:0][RD_W-1:0]        cdb_rd,
  output logic [NUM_CDB-1:0][DATA_LEN-1:0]    cdb_data,
  output logic [NUM_CDB-1:0][SRC_W-1:0]       cdb_src,
  output logic [SRC_W-1:0]                    rr_ptr_o
);

  if (NUM_CDB < 1 || NUM_CDB > NUM_REQ) begin : g_bad_num_cdb
    $error("cdb_arbiter: NUM_CDB must be in 1..NUM_REQ");
  end

  // Handshake: a result moves from FU i when req_valid[i] && req_ready[i];
  // the FU holds valid and payload until granted, nothing is buffered here.

  logic [SRC_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]                grant;
  logic [NUM_CDB-1:0]                lane_vld;
  logic [NUM_CDB-1:0][SRC_W-1:0]     lane_src;
  logic [SRC_W-1:0]                  last_src;
  int                                cnt;
  int                                idx;

  logic [NUM_CDB-1:0]                cdb_valid_q;
  logic [NUM_CDB-1:0][ROB_IDX_W-1:0] cdb_robid_q;
  logic [NUM_CDB-1:0][RD_W-1:0]      cdb_rd_q;
  logic [NUM_CDB-1:0][DATA_LEN-1:0]  cdb_data_q;
  logic [NUM_CDB-1:0][SRC_W-1:0]     cdb_src_q;

  // Circular scan from rr_ptr; the k-th valid requester found takes lane k.
  always_comb begin
    grant    = '0;
    lane_vld = '0;
    lane_src = '0;
    last_src = rr_ptr_q;
    cnt      = 0;
    idx      = 0;
    if (!rst && !flush) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(rr_ptr_q) + k) % NUM_REQ;
        if (req_valid[idx] && cnt < NUM_CDB) begin
          grant[idx]    = 1'b1;
          lane_vld[cnt] = 1'b1;
          lane_src[cnt] = SRC_W'(idx);
          last_src      = SRC_W'(idx);
          cnt           = cnt + 1;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|grant) begin
      rr_ptr_d = SRC_W'((int'(last_src) + 1) % NUM_REQ);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Idle lanes only clear valid; their payload keeps the last broadcast.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= '0;
      cdb_robid_q <= '0;
      cdb_rd_q    <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      cdb_valid_q <= lane_vld;
      for (int k = 0; k < NUM_CDB; k++) begin
        if (lane_vld[k]) begin
          cdb_robid_q[k] <= req_robid[lane_src[k]];
          cdb_rd_q[k]    <= req_rd[lane_src[k]];
          cdb_data_q[k]  <= req_data[lane_src[k]];
          cdb_src_q[k]   <= lane_src[k];
        end
      end
    end
  end

  assign req_ready = grant;
  assign cdb_valid = cdb_valid_q;
  assign cdb_robid = cdb_robid_q;
  assign cdb_rd    = cdb_rd_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;
  assign rr_ptr_o  = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios with literal expectations plus a
// long randomized run checked every cycle against a rotating-priority model.
module tb_cdb_arbiter;
  localparam int NUM_REQ   = 4;
  localparam int NUM_CDB   = 2;
  localparam int ROB_IDX_W = 5;
  localparam int RD_W      = 5;
  localparam int DATA_LEN  = 32;
  localparam int SRC_W     = 2;
  localparam int PW        = ROB_IDX_W + RD_W + DATA_LEN + SRC_W;

  logic                              clk;
  logic                              rst;
  logic                              flush;
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0][ROB_IDX_W-1:0] req_robid;
  logic [NUM_REQ-1:0][RD_W-1:0]      req_rd;
  logic [NUM_REQ-1:0][DATA_LEN-1:0]  req_data;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_CDB-1:0]                cdb_valid;
  logic [NUM_CDB-1:0][ROB_IDX_W-1:0] cdb_robid;
  logic [NUM_CDB-1:0][RD_W-1:0]      cdb_rd;
  logic [NUM_CDB-1:0][DATA_LEN-1:0]  cdb_data;
  logic [NUM_CDB-1:0][SRC_W-1:0]     cdb_src;
  logic [SRC_W-1:0]                  rr_ptr_o;

  cdb_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_CDB(NUM_CDB), .ROB_IDX_W(ROB_IDX_W),
    .RD_W(RD_W), .DATA_LEN(DATA_LEN)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_robid(req_robid), .req_rd(req_rd),
    .req_data(req_data), .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_robid(cdb_robid), .cdb_rd(cdb_rd),
    .cdb_data(cdb_data), .cdb_src(cdb_src), .rr_ptr_o(rr_ptr_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [PW-1:0]      exp_q[$];
  int                 m_ptr = 0;
  logic [NUM_CDB-1:0] m_cdbv = '0;
  logic [PW-1:0]      m_lane [NUM_CDB];
  logic [NUM_REQ-1:0] m_grant = '0;
  int                 m_n = 0;
  bit                 started = 1'b0;
  int                 waitc [NUM_REQ];

  function automatic logic [PW-1:0] fu_payload(input int i);
    return {req_robid[i], req_rd[i], req_data[i], SRC_W'(i)};
  endfunction

  function automatic logic [PW-1:0] lane_payload(input int k);
    return {cdb_robid[k], cdb_rd[k], cdb_data[k], cdb_src[k]};
  endfunction

  always @(negedge clk) begin
    int order[$];
    int n;
    logic [NUM_REQ-1:0] g;
    logic [PW-1:0] e;
    // registered side: what the previous cycle's grants must look like now
    if (started) begin
      chk("cdb_valid", 64'(cdb_valid), 64'(m_cdbv));
      chk("rr_ptr", 64'(rr_ptr_o), 64'(m_ptr));
      for (int k = 0; k < NUM_CDB; k++)
        chk($sformatf("lane%0d_payload", k), 64'(lane_payload(k)), 64'(m_lane[k]));
      for (int k = 0; k < m_n; k++) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("sb_lane%0d", k), 64'(lane_payload(k)), 64'(e));
        end
      end
    end
    // combinational side: requesters in priority order, first NUM_CDB win
    order.delete();
    g = '0;
    n = 0;
    if (!rst && !flush) begin
      for (int k = 0; k < NUM_REQ; k++)
        if (req_valid[(m_ptr + k) % NUM_REQ]) order.push_back((m_ptr + k) % NUM_REQ);
      n = (order.size() < NUM_CDB) ? order.size() : NUM_CDB;
      for (int k = 0; k < n; k++) g[order[k]] = 1'b1;
    end
    chk("req_ready", 64'(req_ready), 64'(g));
    // fairness: a continuously valid FU may be passed over at most once
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst || flush || !req_valid[i] || req_ready[i]) begin
        waitc[i] = 0;
      end else begin
        waitc[i]++;
        chk($sformatf("starve_fu%0d", i), 64'(waitc[i] > 1), 64'(0));
      end
    end
    // advance the model to the state after the coming edge
    m_grant = g;
    if (rst) begin
      m_ptr = 0;
      m_cdbv = '0;
      for (int k = 0; k < NUM_CDB; k++) m_lane[k] = '0;
      exp_q.delete();
      m_n = 0;
      started = 1'b1;
    end else begin
      m_cdbv = '0;
      for (int k = 0; k < n; k++) begin
        m_cdbv[k] = 1'b1;
        m_lane[k] = fu_payload(order[k]);
        exp_q.push_back(fu_payload(order[k]));
      end
      if (n > 0) m_ptr = (order[n-1] + 1) % NUM_REQ;
      m_n = n;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [ROB_IDX_W-1:0] rob,
                         input logic [RD_W-1:0] rd, input logic [DATA_LEN-1:0] d);
    req_valid[i] = v;
    req_robid[i] = rob;
    req_rd[i]    = rd;
    req_data[i]  = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NUM_REQ; i++) waitc[i] = 0;
    rst = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      set_req(i, 1'b1, ROB_IDX_W'(i + 10), RD_W'(i + 1), 32'h1000 + DATA_LEN'(i));

    // reset held 3 cycles with everyone requesting
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'(0));
      chk("rst_cdb_valid", 64'(cdb_valid), 64'(0));
      chk("rst_ptr", 64'(rr_ptr_o), 64'(0));
    end
    step();
    rst = 1'b0;

    // full contention right out of reset
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("cont_ready", 64'(req_ready), (c % 2 == 0) ? 64'h3 : 64'hc);
      chk("cont_ptr", 64'(rr_ptr_o), (c % 2 == 0) ? 64'd0 : 64'd2);
      if (c == 1) begin
        chk("cont_cdb_valid", 64'(cdb_valid), 64'h3);
        chk("cont_src0", 64'(cdb_src[0]), 64'd0);
        chk("cont_src1", 64'(cdb_src[1]), 64'd1);
      end
    end

    // single request from FU2
    step();
    req_valid = '0;
    set_req(2, 1'b1, 5'd7, 5'd3, 32'hDEADBEEF);
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'h4);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("single_cdb_valid", 64'(cdb_valid), 64'h1);
    chk("single_robid", 64'(cdb_robid[0]), 64'd7);
    chk("single_rd", 64'(cdb_rd[0]), 64'd3);
    chk("single_data", 64'(cdb_data[0]), 64'hDEADBEEF);
    chk("single_src", 64'(cdb_src[0]), 64'd2);
    chk("single_ptr", 64'(rr_ptr_o), 64'd3);

    // wrap-around: ptr=3, FU1 and FU3 requesting
    step();
    set_req(1, 1'b1, 5'd21, 5'd0, 32'h11111111);
    set_req(3, 1'b1, 5'd23, 5'd9, 32'h33333333);
    @(negedge clk);
    chk("wrap_ready", 64'(req_ready), 64'ha);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("wrap_cdb_valid", 64'(cdb_valid), 64'h3);
    chk("wrap_src0", 64'(cdb_src[0]), 64'd3);
    chk("wrap_src1", 64'(cdb_src[1]), 64'd1);
    chk("wrap_rd0_broadcast", 64'(cdb_rd[1]), 64'd0);
    chk("wrap_ptr", 64'(rr_ptr_o), 64'd2);

    // flush: FU0 granted in N, flush in N+1 with FU1 waiting
    step();
    set_req(0, 1'b1, 5'd30, 5'd4, 32'hA5A5A5A5);
    @(negedge clk);
    chk("flush_n_ready", 64'(req_ready), 64'h1);
    step();
    req_valid = '0;
    set_req(1, 1'b1, 5'd31, 5'd5, 32'h5A5A5A5A);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_n1_cdb_valid", 64'(cdb_valid), 64'h1);
    chk("flush_n1_src", 64'(cdb_src[0]), 64'd0);
    chk("flush_n1_ready", 64'(req_ready), 64'h0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_n2_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("flush_n2_ready", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("flush_n3_src", 64'(cdb_src[0]), 64'd1);
    chk("flush_n3_data", 64'(cdb_data[0]), 64'h5A5A5A5A);

    // randomized run; ungranted requesters hold valid and payload
    for (int c = 0; c < 10000; c++) begin
      step();
      rst   = ($urandom_range(0, 499) == 0);
      flush = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!(req_valid[i] && !m_grant[i])) begin
          set_req(i, ($urandom_range(0, 9) < 6), ROB_IDX_W'($urandom),
                  ($urandom_range(0, 7) == 0) ? '0 : RD_W'($urandom), $urandom);
        end
      end
    end
    step();
    rst = 1'b0;
    flush = 1'b0;
    req_valid = '0;
    repeat (3) @(negedge clk);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
